// File: rtl/coreriscv_axi4_release_sequencer_pkg.sv
// Release sequencer shared definitions: block geometry, release type
// encodings, has_data() (also used by the release arbiter lock) and FSM states.
package coreriscv_axi4_release_sequencer_pkg;

  localparam int BEATS   = 8;
  localparam int BEAT_W  = 3;
  localparam int DATA_W  = 64;
  localparam int BLOCK_W = 26;

  localparam logic [2:0] REL_VOL_WB     = 3'd0;
  localparam logic [2:0] REL_INV_DATA   = 3'd1;
  localparam logic [2:0] REL_SHR_DATA   = 3'd2;
  localparam logic [2:0] REL_INV_ACK    = 3'd3;
  localparam logic [2:0] REL_DATA_MAX   = REL_SHR_DATA;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_SINGLE
  } rel_state_e;

  function automatic logic has_data(input logic [2:0] r_type);
    return r_type <= REL_DATA_MAX;
  endfunction

endpackage

// File: rtl/coreriscv_axi4_release_beat_fifo.sv
// Two-entry beat buffer between the data-array read port and the arbiter.
// Ports: push/push_data in, pop in, head/count out; clk, reset_n (sync, low).
module coreriscv_axi4_release_beat_fifo
  import coreriscv_axi4_release_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              rd_ptr;
  logic              wr_ptr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(push && !pop && count == 2'd2));

  a_no_underflow: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(pop && count == 2'd0));

endmodule

// File: rtl/coreriscv_axi4_release_sequencer.sv
// Turns one L1 release request into a beat stream for the release arbiter.
// Ports: req_* (request in), rd_* (data-array read), out_* (arbiter side),
// done pulse, stall_cnt (live when CORERISCV_AXI4_RELEASE_SEQ_STALL_CNT_EN).
module coreriscv_axi4_release_sequencer
  import coreriscv_axi4_release_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_src,
  input  logic [1:0]         req_dst,
  input  logic [BLOCK_W-1:0] req_addr_block,
  input  logic               req_client_xact_id,
  input  logic               req_voluntary,
  input  logic [2:0]         req_r_type,
  output logic               rd_en,
  output logic [BLOCK_W-1:0] rd_addr_block,
  output logic [BEAT_W-1:0]  rd_addr_beat,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_header_src,
  output logic [1:0]         out_header_dst,
  output logic [BEAT_W-1:0]  out_addr_beat,
  output logic [BLOCK_W-1:0] out_addr_block,
  output logic               out_client_xact_id,
  output logic               out_voluntary,
  output logic [2:0]         out_r_type,
  output logic [DATA_W-1:0]  out_data,
  output logic               done,
  output logic [15:0]        stall_cnt
);

  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(BEATS - 1);

  rel_state_e state, state_nxt;

  logic [1:0]         src_q;
  logic [1:0]         dst_q;
  logic [BLOCK_W-1:0] block_q;
  logic               xid_q;
  logic               vol_q;
  logic [2:0]         r_type_q;

  logic [BEAT_W-1:0]  rd_beat;
  logic [BEAT_W-1:0]  tx_beat;
  logic               rd_last;
  logic               inflight;
  logic [1:0]         fifo_count;
  logic [DATA_W-1:0]  fifo_head;
  logic [2:0]         credit;
  logic               pop;
  logic               last_fire;
  logic               req_fire;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // buffered + in flight - leaving now; pop implies count >= 1
  assign credit = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};

  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    out_valid     = 1'b0;
    rd_en         = 1'b0;
    pop           = 1'b0;
    last_fire     = 1'b0;
    out_addr_beat = '0;
    out_data      = '0;
    unique case (state)
      ST_IDLE: begin
        req_ready = reset_n;
        if (req_valid && reset_n)
          state_nxt = has_data(req_r_type) ? ST_DATA : ST_SINGLE;
      end
      ST_SINGLE: begin
        out_valid = reset_n;
        if (out_valid && out_ready) begin
          last_fire = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        out_valid     = reset_n && (fifo_count != 2'd0);
        out_data      = fifo_head;
        out_addr_beat = tx_beat;
        pop           = out_valid && out_ready;
        rd_en         = reset_n && !rd_last && (credit < 3'd2);
        if (pop && tx_beat == LAST) begin
          last_fire = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign req_fire = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_beat  <= '0;
      tx_beat  <= '0;
      rd_last  <= 1'b0;
      inflight <= 1'b0;
      done     <= 1'b0;
    end else begin
      inflight <= rd_en;
      done     <= last_fire;
      if (req_fire) begin
        rd_beat <= '0;
        tx_beat <= '0;
        rd_last <= 1'b0;
      end
      if (rd_en) begin
        rd_beat <= rd_beat + 1'b1;
        if (rd_beat == LAST) rd_last <= 1'b1;
      end
      if (pop) tx_beat <= tx_beat + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      src_q    <= '0;
      dst_q    <= '0;
      block_q  <= '0;
      xid_q    <= 1'b0;
      vol_q    <= 1'b0;
      r_type_q <= '0;
    end else if (req_fire) begin
      src_q    <= req_src;
      dst_q    <= req_dst;
      block_q  <= req_addr_block;
      xid_q    <= req_client_xact_id;
      vol_q    <= req_voluntary;
      r_type_q <= req_r_type;
    end
  end

  assign rd_addr_block      = block_q;
  assign rd_addr_beat       = rd_beat;
  assign out_header_src     = src_q;
  assign out_header_dst     = dst_q;
  assign out_addr_block     = block_q;
  assign out_client_xact_id = xid_q;
  assign out_voluntary      = vol_q;
  assign out_r_type         = r_type_q;

  coreriscv_axi4_release_beat_fifo u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data (rd_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

`ifdef CORERISCV_AXI4_RELEASE_SEQ_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (!reset_n)
      stall_q <= 16'h0;
    else if (out_valid && !out_ready && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_coreriscv_axi4_release_sequencer.sv
// Directed bench for the release sequencer: vector table of release
// scenarios plus reset, back-to-back and stall-count sequences.
module tb_coreriscv_axi4_release_sequencer;
  import coreriscv_axi4_release_sequencer_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_src, req_dst;
  logic [BLOCK_W-1:0] req_addr_block;
  logic               req_client_xact_id, req_voluntary;
  logic [2:0]         req_r_type;
  logic               rd_en;
  logic [BLOCK_W-1:0] rd_addr_block;
  logic [BEAT_W-1:0]  rd_addr_beat;
  logic [DATA_W-1:0]  rd_data;
  logic               out_valid, out_ready;
  logic [1:0]         out_header_src, out_header_dst;
  logic [BEAT_W-1:0]  out_addr_beat;
  logic [BLOCK_W-1:0] out_addr_block;
  logic               out_client_xact_id, out_voluntary;
  logic [2:0]         out_r_type;
  logic [DATA_W-1:0]  out_data;
  logic               done;
  logic [15:0]        stall_cnt;

  int total = 0;
  int bad = 0;

`ifdef CORERISCV_AXI4_RELEASE_SEQ_STALL_CNT_EN
  localparam int STALL_EXP = 20;
`else
  localparam int STALL_EXP = 0;
`endif

  always #5 clk = ~clk;

  coreriscv_axi4_release_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst),
    .req_addr_block(req_addr_block),
    .req_client_xact_id(req_client_xact_id),
    .req_voluntary(req_voluntary), .req_r_type(req_r_type),
    .rd_en(rd_en), .rd_addr_block(rd_addr_block),
    .rd_addr_beat(rd_addr_beat), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_header_src(out_header_src), .out_header_dst(out_header_dst),
    .out_addr_beat(out_addr_beat), .out_addr_block(out_addr_block),
    .out_client_xact_id(out_client_xact_id),
    .out_voluntary(out_voluntary), .out_r_type(out_r_type),
    .out_data(out_data), .done(done), .stall_cnt(stall_cnt)
  );

  function automatic logic [63:0] mem_word(input logic [25:0] b,
                                           input logic [2:0] beat);
    return {b, 3'b101, beat, 29'h0, beat};
  endfunction

  // data array: answers one cycle after rd_en, noise otherwise
  always @(posedge clk)
    rd_data <= rd_en ? mem_word(rd_addr_block, rd_addr_beat)
                     : {$urandom, $urandom};

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]         r_type;
    logic [BLOCK_W-1:0] block;
    logic [1:0]         src;
    logic [1:0]         dst;
    logic               xid;
    logic               vol;
    logic [3:0]         pat;
    int                 plen;
    int                 beats;
    int                 done_cyc;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    int rd_n = 0;
    int tx_n = 0;
    int done_at = -1;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_r_type = v.r_type;
    req_addr_block = v.block;
    req_src = v.src;
    req_dst = v.dst;
    req_client_xact_id = v.xid;
    req_voluntary = v.vol;
    out_ready = 1'b0;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 40 && done_at < 0; c++) begin
      out_ready = v.pat[(c - 1) % v.plen];
      @(negedge clk);
      chk("req_ready_busy", req_ready, done);
      if (rd_en) begin
        chk("rd_block", rd_addr_block, v.block);
        chk("rd_beat", rd_addr_beat, rd_n);
        rd_n++;
      end
      chk("credit", (rd_n - tx_n - int'(out_valid && out_ready)) <= 2, 1);
      if (out_valid) begin
        chk("hdr", {out_header_src, out_header_dst, out_client_xact_id,
                    out_voluntary, out_r_type},
                   {v.src, v.dst, v.xid, v.vol, v.r_type});
        chk("out_block", out_addr_block, v.block);
        chk("out_beat", out_addr_beat, tx_n);
        chk("out_data", out_data,
            has_data(v.r_type) ? mem_word(v.block, tx_n[2:0]) : 64'h0);
        if (out_ready) tx_n++;
      end
      if (done) done_at = c;
      @(posedge clk); #1;
    end
    chk("beats", tx_n, v.beats);
    chk("reads", rd_n, has_data(v.r_type) ? 8 : 0);
    chk("done_cycle", done_at, v.done_cyc);
  endtask

  initial begin
    int n;
    vec_t clean;
    vecs[0] = '{3'd0, 26'h123, 2'd1, 2'd2, 1'b1, 1'b1, 4'b1111, 1, 8, 11};
    vecs[1] = '{3'd3, 26'h0ABCDEF, 2'd3, 2'd0, 1'b0, 1'b0, 4'b1111, 1, 1, 2};
    vecs[2] = '{3'd1, 26'h2000001, 2'd2, 2'd1, 1'b1, 1'b0, 4'b1001, 4, 8, 18};
    vecs[3] = '{3'd7, 26'h3FFFFFF, 2'd0, 2'd3, 1'b0, 1'b1, 4'b0100, 3, 1, 4};
    vecs[4] = '{3'd2, 26'h3FFFFFF, 2'd1, 2'd1, 1'b1, 1'b1, 4'b0010, 2, 8, 19};
    clean   = '{3'd0, 26'h0F0F0F0, 2'd2, 2'd2, 1'b0, 1'b1, 4'b1111, 1, 8, 11};

    reset_n = 1'b0;
    req_valid = 1'b0;
    req_src = '0;
    req_dst = '0;
    req_addr_block = '0;
    req_client_xact_id = 1'b0;
    req_voluntary = 1'b0;
    req_r_type = '0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("rst_low_outs", {req_ready, out_valid, rd_en}, 3'b000);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_state", {done, req_ready, out_valid, rd_en}, 4'b0100);
    chk("rst_stall", stall_cnt, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // reset in the middle of a data release
    @(posedge clk); #1;
    req_r_type = 3'd0;
    req_addr_block = 26'h155;
    req_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_xfer_busy", {out_valid, req_ready}, 2'b10);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_low", {req_ready, out_valid, rd_en}, 3'b000);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_after", {done, req_ready, out_valid, rd_en}, 4'b0100);
    chk("rst_mid_stall", stall_cnt, 0);
    run_vec(clean);

    // back-to-back with req_valid held
    @(posedge clk); #1;
    req_r_type = 3'd0;
    req_addr_block = 26'h111;
    req_src = 2'd0;
    req_dst = 2'd1;
    req_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    req_r_type = 3'd5;
    req_addr_block = 26'h222;
    req_src = 2'd2;
    req_dst = 2'd3;
    n = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("b2b_a_beat", {out_addr_block, out_addr_beat},
            {26'h111, n[2:0]});
        n++;
      end
      if (c == 11) chk("b2b_accept_in_done", {done, req_ready}, 2'b11);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("b2b_a_count", n, 8);
    @(negedge clk);
    chk("b2b_b_beat", {out_valid, rd_en, out_addr_block, out_r_type,
                       out_header_src, out_header_dst, out_addr_beat},
        {1'b1, 1'b0, 26'h222, 3'd5, 2'd2, 2'd3, 3'd0});
    chk("b2b_b_data", out_data, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_b_done", done, 1);

    // 20 stalled cycles on a dataless beat
    chk("stall_pre", stall_cnt, 0);
    @(posedge clk); #1;
    req_r_type = 3'd4;
    req_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    @(negedge clk);
    chk("stall_cnt", stall_cnt, STALL_EXP);
    chk("stall_hold", {out_valid, out_addr_beat, out_r_type},
        {1'b1, 3'd0, 3'd4});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("stall_done", {done, stall_cnt}, {1'b1, 16'(STALL_EXP)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coreriscv_axi4_release_sequencer.md
# coreriscv_axi4_release_sequencer

Sequences one L1 release (voluntary writeback or probe response) from a cache request into a beat stream on one input port of the locking round-robin release arbiter. Data-bearing releases read the data array over 8 beats through a 2-entry buffer; dataless releases go out as a single beat. The block sits between the cache writeback/probe unit and the release arbiter input.

## Interface
- BEATS, 8: data beats per block
- BEAT_W, 3: beat index width
- DATA_W, 64: beat data width
- BLOCK_W, 26: block address width
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous reset, active-low
- req_valid / req_ready  in / out  1  release request handshake
- req_src, req_dst  in  2  network header
- req_addr_block  in  BLOCK_W  block address
- req_client_xact_id, req_voluntary  in  1  payload fields
- req_r_type  in  3  release type; 0..2 carry data, 3..7 are dataless
- rd_en  out  1  data-array read strobe
- rd_addr_block  out  BLOCK_W  read block address
- rd_addr_beat  out  BEAT_W  read beat index
- rd_data  in  DATA_W  valid exactly 1 cycle after rd_en
- out_valid / out_ready  out / in  1  arbiter-input handshake
- out_header_src, out_header_dst  out  2
- out_addr_beat  out  BEAT_W
- out_addr_block  out  BLOCK_W
- out_client_xact_id, out_voluntary  out  1
- out_r_type  out  3
- out_data  out  DATA_W
- done  out  1  one-cycle pulse after the last beat is accepted
- stall_cnt  out  16  saturating backpressure count (see Configuration)

## Operation
- States: IDLE, DATA, SINGLE.
- IDLE: req_ready=1. On req fire, latch all request fields. r_type<=2 -> DATA, with rd_beat=0 and tx_beat=0. Otherwise -> SINGLE.
- SINGLE: out_valid=1, out_addr_beat=0, out_data=0. On out fire -> IDLE.
- DATA read side:
  - rd_en=1 when rd_beat<BEATS and (fifo_count + inflight − pop_this_cycle) < 2.
  - rd_addr_beat=rd_beat, which increments on each rd_en.
  - inflight is a 1-bit register set by rd_en. rd_data is pushed into the FIFO in the cycle after rd_en.
- DATA send side:
  - out_valid = FIFO non-empty; out_data = FIFO head; out_addr_beat = tx_beat.
  - Pop on out fire, and tx_beat increments.
  - Fire with tx_beat=BEATS−1 -> IDLE.
- Beat counters are BEAT_W bits. rd_beat uses a separate terminal flag so the counter never wraps to reissue beat 0.
- done: registered, high for 1 cycle following the last-beat fire in either DATA or SINGLE.
- Header and payload outputs come from latched registers and stay stable while out_valid && !out_ready. out_valid is never withdrawn before fire.
- req_ready=0 in DATA and SINGLE. A new request is accepted only in IDLE, so the earliest acceptance is the cycle done is high.
- FIFO overflow is impossible by the credit rule. Writing into a full FIFO is a design error (assertion).

## Timing
- Reset (reset_n low at an edge) forces:
  - state=IDLE
  - FIFO empty, inflight=0, counters=0
  - done=0, out_valid=0, rd_en=0, stall_cnt=0, req_ready=0 while reset_n is low.
- Reset mid-transfer: the transfer is dropped. rd_data returning after reset is ignored.
- Req fire at cycle 0 -> rd_en at cycle 1 -> first out_valid at cycle 3.
- With out_ready held high, beats go out at cycles 3..10 and done pulses at cycle 11.
- Dataless: req fire at cycle 0 -> out_valid at cycle 1; fire at cycle 1 -> done at cycle 2.
- Sustained throughput is 1 beat/cycle. Under backpressure, at most 2 beats are buffered plus 0 in flight.

## Configuration
- CORERISCV_AXI4_RELEASE_SEQ_STALL_CNT_EN defined:
  - stall_cnt increments each cycle with out_valid && !out_ready and saturates at 16'hFFFF.
  - It clears only on reset.
- Undefined: stall_cnt is tied to 16'h0 and no counter register exists.

## Structure
- Shared package holds:
  - widths BEAT_W, DATA_W, BLOCK_W, BEATS
  - r_type encodings and the has_data(r_type) function (r_type<=2), shared with the release arbiter's lock logic
  - the state enum
- Sub-module: coreriscv_axi4_release_beat_fifo, a 2-entry, DATA_W-wide FIFO with count output.

## Test plan
- r_type=0, addr_block=26'h123, out_ready=1 -> rd_addr_beat 0..7 on cycles 1..8; out_addr_beat 0..7 on cycles 3..10 with data matching the array; done at cycle 11.
- r_type=3 -> no rd_en; a single beat with out_addr_beat=0 and out_data=0 at cycle 1; done at cycle 2.
- r_type=1 with out_ready toggling 1,0,0,1,… -> beats in order with no loss or duplication; FIFO count ≤2; rd_en stalls when the credit is exhausted; outputs stable while stalled.
- reset_n low at cycle 5 of a data release -> all outputs at reset values next cycle; a new request is accepted cleanly; stale rd_data is not pushed.
- Back-to-back requests with req_valid held -> the second is accepted in the done cycle; its beats are not interleaved with the first.
- Macro defined, out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt=20. Macro undefined -> stall_cnt stays 0.
